la_seq_checker: RTL and testbench

- Synthesizable monitor for self-checking LA/GPIO firmware tests inside the user project area.
- Watches a step-code field and a status field driven by firmware, typically mprj_io[25:20] and mprj_io[37:36].
- Enforces the sequence 0,1,…,LAST_STEP. After each step, the status field must read STAT_OK before the next step is accepted.
- Reports pass/fail, a fail code, the current step and the elapsed cycle count, so one checker serves every la_testN without a per-test bench.

---
 rtl/la_seq_pkg.sv | 28 ++
 rtl/la_seq_sync.sv | 29 ++
 rtl/la_seq_checker.sv | 214 +++++++++++++++++++++
 tb/tb_la_seq_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_seq_pkg.sv
// Shared types and constants for the LA/GPIO step-sequence checker.
package la_seq_pkg;

   // Checker FSM states.
   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      WAIT_STEP,
      WAIT_OK,
      PASS,
      FAIL
   } state_e;

   // Fail codes reported on fail_code_o.
   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_TIMEOUT = 2'd1;
   localparam logic [1:0] FC_ORDER   = 2'd2;
   localparam logic [1:0] FC_REGRESS = 2'd3;

   // Width of the elapsed-cycle counter.
   localparam int CYCLES_W = 32;

   // The checker is busy while it is waiting for firmware to make progress.
   function automatic logic is_busy(input state_e s);
      return (s == WAIT_START) || (s == WAIT_STEP) || (s == WAIT_OK);
   endfunction

endpackage

// File: rtl/la_seq_sync.sv
// Two-flop synchronizer for the asynchronous pad/LA step and status fields.
module la_seq_sync #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two register stages with synchronous clear.
   // NOTE: clocked state uses non-blocking assignments so both stages sample
   // the pre-edge values; blocking here would collapse the chain to one flop.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/la_seq_checker.sv
// Step-sequence checker for self-checking LA/GPIO firmware tests.
// Firmware walks a step code 0..LAST_STEP and reports a status per step;
// the checker flags pass, timeout, regression and (optionally) skipped steps.
// Build option: define LA_SEQ_CHECK_STRICT_EN to fail (code 2) on a skipped
// step; by default unexpected forward step codes are ignored.
module la_seq_checker
   import la_seq_pkg::*;
#(
   parameter int          STEP_W         = 6,
   parameter int          LAST_STEP      = 16,
   parameter int          STAT_W         = 2,
   parameter int          STAT_OK        = 0,
   parameter logic [63:0] STAT_SKIP_MASK = 64'h10,
   parameter int          TIMEOUT_W      = 24
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 enable_i,
   input  logic [STEP_W-1:0]    step_i,
   input  logic [STAT_W-1:0]    stat_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   output logic [STEP_W-1:0]    step_o,
   output logic                 busy_o,
   output logic                 pass_o,
   output logic                 fail_o,
   output logic [1:0]           fail_code_o,
   output logic [CYCLES_W-1:0]  cycles_o
);

   localparam logic [STEP_W-1:0] LAST_C    = STEP_W'(LAST_STEP);
   localparam logic [STAT_W-1:0] STAT_OK_C = STAT_W'(STAT_OK);

   // Synchronized views of the raw pad fields.
   logic [STEP_W+STAT_W-1:0] sync_w;
   logic [STEP_W-1:0]        step_s;
   logic [STAT_W-1:0]        stat_s;

   la_seq_sync #(
      .W (STEP_W + STAT_W)
   ) u_sync (
      .clk_i (wb_clk_i),
      .rst_i (wb_rst_i),
      .d_i   ({step_i, stat_i}),
      .q_o   (sync_w)
   );

   assign step_s = sync_w[STEP_W+STAT_W-1:STAT_W];
   assign stat_s = sync_w[STAT_W-1:0];

   // Registered state.
   state_e                state_q;
   logic [STEP_W-1:0]     exp_q;
   logic [STEP_W-1:0]     step_q;
   logic [TIMEOUT_W-1:0]  timer_q;
   logic [CYCLES_W-1:0]   cycles_q;
   logic                  pass_q;
   logic                  fail_q;
   logic [1:0]            fc_q;

   // Event decode.
   logic in_seq;
   logic regress;
   logic step_hit;
   logic stat_hit;
   logic skip_stat;
   logic is_last;
   logic order_err;
   logic timeout_hit;

   // Decode this cycle's events from the synchronized inputs and current state.
   // NOTE: every signal gets a default at the top of the block so no path can
   // leave it unassigned, which would otherwise infer a latch.
   always_comb begin
      in_seq      = 1'b0;
      regress     = 1'b0;
      step_hit    = 1'b0;
      stat_hit    = 1'b0;
      order_err   = 1'b0;
      in_seq      = (state_q == WAIT_STEP) || (state_q == WAIT_OK);
      regress     = in_seq && (step_s < step_q);
      step_hit    = (state_q == WAIT_STEP) && (step_s == exp_q);
      stat_hit    = (state_q == WAIT_OK) && (stat_s == STAT_OK_C);
      skip_stat   = STAT_SKIP_MASK[exp_q];
      is_last     = (exp_q == LAST_C);
      timeout_hit = (timeout_i != '0) && (timer_q == timeout_i);
`ifdef LA_SEQ_CHECK_STRICT_EN
      order_err   = (state_q == WAIT_STEP) && (step_s != step_q) &&
                    (step_s != exp_q) && (step_s > step_q);
`else
      order_err   = 1'b0;
`endif
   end

   // Sequence FSM with registered outputs; priority inside a wait state is
   // regression, then advance, then skipped-step, then timeout.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         exp_q    <= STEP_W'(1);
         step_q   <= '0;
         timer_q  <= '0;
         cycles_q <= '0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         fc_q     <= FC_NONE;
      end else if (!enable_i) begin
         // Abort: back to idle with clean outputs; not reported as a failure.
         state_q  <= IDLE;
         exp_q    <= STEP_W'(1);
         step_q   <= '0;
         timer_q  <= '0;
         cycles_q <= '0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         fc_q     <= FC_NONE;
      end else begin
         // Elapsed time runs only once step 0 has been seen, and saturates.
         if (in_seq && (cycles_q != '1)) begin
            cycles_q <= cycles_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               state_q  <= WAIT_START;
               timer_q  <= '0;
               cycles_q <= '0;
            end

            WAIT_START: begin
               if (step_s == '0) begin
                  state_q <= WAIT_STEP;
                  step_q  <= '0;
                  exp_q   <= STEP_W'(1);
                  timer_q <= '0;
               end else if (timeout_hit) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  fc_q    <= FC_TIMEOUT;
               end else if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            WAIT_STEP: begin
               if (regress) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  fc_q    <= FC_REGRESS;
               end else if (step_hit) begin
                  step_q  <= exp_q;
                  timer_q <= '0;
                  if (skip_stat) begin
                     // Step does not wait for a status report.
                     if (is_last) begin
                        state_q <= PASS;
                        pass_q  <= 1'b1;
                     end else begin
                        exp_q <= exp_q + 1'b1;
                     end
                  end else begin
                     state_q <= WAIT_OK;
                  end
               end else if (order_err) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  fc_q    <= FC_ORDER;
               end else if (timeout_hit) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  fc_q    <= FC_TIMEOUT;
               end else if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            WAIT_OK: begin
               if (regress) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  fc_q    <= FC_REGRESS;
               end else if (stat_hit) begin
                  timer_q <= '0;
                  if (is_last) begin
                     state_q <= PASS;
                     pass_q  <= 1'b1;
                  end else begin
                     state_q <= WAIT_STEP;
                     exp_q   <= exp_q + 1'b1;
                  end
               end else if (timeout_hit) begin
                  state_q <= FAIL;
                  fail_q  <= 1'b1;
                  fc_q    <= FC_TIMEOUT;
               end else if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
            end

            // PASS and FAIL are terminal until enable_i drops.
            PASS:    state_q <= PASS;
            FAIL:    state_q <= FAIL;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign step_o      = step_q;
   assign busy_o      = is_busy(state_q);
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign fail_code_o = fc_q;
   assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_la_seq_checker.sv
// Directed testbench for la_seq_checker (default parameters).
// Flags vector compared below is {busy, pass, fail, fail_code[1:0], step[5:0]}.
module tb_la_seq_checker;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [5:0]  step_in;
   logic [1:0]  stat_in;
   logic [23:0] timeout;
   logic [5:0]  step_o;
   logic        busy_o;
   logic        pass_o;
   logic        fail_o;
   logic [1:0]  fail_code_o;
   logic [31:0] cycles_o;

   int n_cmp = 0;
   int n_bad = 0;
   int tcount = 0;
   int exp_cycles;

   wire [10:0] flags = {busy_o, pass_o, fail_o, fail_code_o, step_o};

   la_seq_checker #(
      .STEP_W         (6),
      .LAST_STEP      (16),
      .STAT_W         (2),
      .STAT_OK        (0),
      .STAT_SKIP_MASK (64'h10),
      .TIMEOUT_W      (24)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .enable_i    (enable),
      .step_i      (step_in),
      .stat_i      (stat_in),
      .timeout_i   (timeout),
      .step_o      (step_o),
      .busy_o      (busy_o),
      .pass_o      (pass_o),
      .fail_o      (fail_o),
      .fail_code_o (fail_code_o),
      .cycles_o    (cycles_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         tcount++;
      end
   endtask

   // Abort, re-arm with the given timeout and present step 0; ends in WAIT_STEP.
   task automatic restart(input int t);
      enable  = 1'b0;
      step_in = 6'd63;
      stat_in = 2'd3;
      tick(3);
      timeout = 24'(t);
      enable  = 1'b1;
      tick(1);
      step_in = 6'd0;
      tcount  = 0;
      tick(3);
   endtask

   // Present a step code and status, then wait long enough for it to settle.
   task automatic drive(input int s, input int st, input int n);
      step_in = 6'(s);
      stat_in = 2'(st);
      tick(n);
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; step_in = 6'd0; stat_in = 2'd0; timeout = 24'd0;
      tick(2);
      n_cmp++;
      if ({flags, cycles_o} !== {11'd0, 32'd0}) begin
         n_bad++; $display("FAIL reset_outputs: got %b/%0d want all zero", flags, cycles_o);
      end
      rst = 1'b0;
      tick(2);
      n_cmp++;
      if (flags !== 11'd0) begin
         n_bad++; $display("FAIL idle_disabled: got %b want 0", flags);
      end
      enable = 1'b1;
      tick(1);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd0}) begin
         n_bad++; $display("FAIL wait_start_busy: got %b", flags);
      end
   endtask

   task automatic test_full_sequence();
      restart(0);
      n_cmp++;
      if ({flags, cycles_o} !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 32'd0}) begin
         n_bad++; $display("FAIL seq_start: got %b/%0d want busy step 0 cycles 0", flags, cycles_o);
      end
      tick(10);
      n_cmp++;
      if (cycles_o !== 32'd10) begin
         n_bad++; $display("FAIL seq_cycles_count: got %0d want 10", cycles_o);
      end
      for (int n = 1; n <= 16; n++) begin
         if (n == 16) exp_cycles = tcount + 1;
         // Step 4 is status-exempt: hold a non-OK status there to prove it.
         drive(n, (n == 4) ? 3 : 0, 4);
         if (n == 4 || n == 8) begin
            n_cmp++;
            if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'(n)}) begin
               n_bad++; $display("FAIL seq_step_%0d: got %b", n, flags);
            end
         end
      end
      n_cmp++;
      if (flags !== {1'b0, 1'b1, 1'b0, 2'd0, 6'd16}) begin
         n_bad++; $display("FAIL seq_pass: got %b want pass step 16", flags);
      end
      tick(5);
      n_cmp++;
      if (cycles_o !== 32'(exp_cycles)) begin
         n_bad++; $display("FAIL seq_cycles_frozen: got %0d want %0d", cycles_o, exp_cycles);
      end
   endtask

   task automatic test_timeout();
      restart(100);
      drive(1, 0, 4);
      drive(2, 0, 4);
      drive(3, 3, 3);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd3}) begin
         n_bad++; $display("FAIL to_enter_wait_ok: got %b", flags);
      end
      // Timer reaches 100 after 100 cycles in WAIT_OK; fail registers next edge.
      tick(100);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd3}) begin
         n_bad++; $display("FAIL to_not_early: got %b", flags);
      end
      tick(1);
      n_cmp++;
      if (flags !== {1'b0, 1'b0, 1'b1, 2'd1, 6'd3}) begin
         n_bad++; $display("FAIL to_fail: got %b want fail code 1 step 3", flags);
      end
   endtask

   task automatic test_regression();
      restart(0);
      for (int n = 1; n <= 5; n++) drive(n, 0, 4);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd5}) begin
         n_bad++; $display("FAIL reg_step5: got %b", flags);
      end
      drive(2, 0, 3);
      n_cmp++;
      if (flags !== {1'b0, 1'b0, 1'b1, 2'd3, 6'd5}) begin
         n_bad++; $display("FAIL reg_fail: got %b want fail code 3 step 5", flags);
      end
   endtask

   task automatic test_skip();
      restart(0);
      drive(1, 0, 4);
      drive(3, 0, 4);
`ifdef LA_SEQ_CHECK_STRICT_EN
      n_cmp++;
      if (flags !== {1'b0, 1'b0, 1'b1, 2'd2, 6'd1}) begin
         n_bad++; $display("FAIL skip_strict: got %b want fail code 2 step 1", flags);
      end
`else
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd1}) begin
         n_bad++; $display("FAIL skip_ignored: got %b want busy step 1", flags);
      end
      drive(2, 0, 4);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd2}) begin
         n_bad++; $display("FAIL skip_step2: got %b", flags);
      end
      for (int n = 3; n <= 16; n++) drive(n, 0, 4);
      n_cmp++;
      if (flags !== {1'b0, 1'b1, 1'b0, 2'd0, 6'd16}) begin
         n_bad++; $display("FAIL skip_pass: got %b want pass step 16", flags);
      end
`endif
   endtask

   task automatic test_abort_reset();
      restart(0);
      for (int n = 1; n <= 6; n++) drive(n, 0, 4);
      drive(7, 3, 3);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd7}) begin
         n_bad++; $display("FAIL abort_at7: got %b", flags);
      end
      enable = 1'b0;
      tick(1);
      n_cmp++;
      if ({flags, cycles_o} !== {11'd0, 32'd0}) begin
         n_bad++; $display("FAIL abort_idle: got %b/%0d want all zero", flags, cycles_o);
      end
      enable = 1'b1;
      drive(0, 3, 3);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd0}) begin
         n_bad++; $display("FAIL rearm_step0: got %b", flags);
      end
      drive(1, 3, 3);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd1}) begin
         n_bad++; $display("FAIL rearm_step1: got %b", flags);
      end
      rst = 1'b1;
      tick(1);
      n_cmp++;
      if ({flags, cycles_o} !== {11'd0, 32'd0}) begin
         n_bad++; $display("FAIL midrun_reset: got %b/%0d want all zero", flags, cycles_o);
      end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_boundary();
      // Timeout disabled: a stalled status never fails.
      restart(0);
      drive(1, 3, 3);
      tick(300);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd1}) begin
         n_bad++; $display("FAIL no_timeout: got %b want busy step 1", flags);
      end
      // Status OK lands on the very cycle the timer equals timeout_i.
      restart(20);
      drive(1, 3, 21);
      drive(1, 0, 3);
      n_cmp++;
      if (flags !== {1'b1, 1'b0, 1'b0, 2'd0, 6'd1}) begin
         n_bad++; $display("FAIL adv_beats_to: got %b want busy no fail", flags);
      end
      // One cycle later than that, the timeout wins.
      drive(2, 3, 22);
      drive(2, 0, 3);
      n_cmp++;
      if (flags !== {1'b0, 1'b0, 1'b1, 2'd1, 6'd2}) begin
         n_bad++; $display("FAIL to_one_late: got %b want fail code 1 step 2", flags);
      end
   endtask

   initial begin
      test_reset();
      test_full_sequence();
      test_timeout();
      test_regression();
      test_skip();
      test_abort_reset();
      test_boundary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
